// File: rtl/load_store_unit.sv
// Data-memory load/store responder for the single-cycle RV32I core: valid/ready bus access, core stall, load extension.
// Optional bus-wait timeout enabled by defining LSU_TIMEOUT_EN (bus_err tied low otherwise).
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; illegal requests go straight to DONE
// BUSY  | bus_req held high with stable request fields until bus_ready (or timeout)
// DONE  | one cycle with stall low so the core retires; error pulses live here
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              access_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state, state_nx;
    logic        req, illegal, is_half, is_word;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;
    logic [2:0]  op_f3;
    logic [1:0]  op_ofs;
    logic [15:0] sh16;
    logic [31:0] ext;
    logic        tmo, finish;

    always_comb begin
        req     = mem_read | mem_write;
        is_half = (funct3[1:0] == 2'b01);
        is_word = (funct3[1:0] == 2'b10);
        illegal = 1'b0;
        if (mem_read && mem_write)
            illegal = 1'b1;
        if (mem_read && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            illegal = 1'b1;
        if (mem_write && (funct3[2] || funct3[1:0] == 2'b11))
            illegal = 1'b1;
        if (is_half && addr[0])
            illegal = 1'b1;
        if (is_word && addr[1:0] != 2'b00)
            illegal = 1'b1;

        be_nx    = 4'b0000;
        wdata_nx = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_nx    = 4'b0001 << addr[1:0];
                wdata_nx = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nx    = 4'b0011 << addr[1:0];
                wdata_nx = {2{wdata[15:0]}};
            end
            2'b10: be_nx = 4'b1111;
            default: be_nx = 4'b0000;
        endcase
    end

    // Lane extraction uses the offset and funct3 latched when the request was accepted.
    always_comb begin
        sh16 = 16'(bus_rdata >> {op_ofs, 3'b000});
        case (op_f3)
            3'b000:  ext = {{24{sh16[7]}}, sh16[7:0]};
            3'b100:  ext = {24'h0, sh16[7:0]};
            3'b001:  ext = {{16{sh16[15]}}, sh16};
            3'b101:  ext = {16'h0, sh16};
            default: ext = bus_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign tmo = !bus_ready && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (state == S_IDLE)
                wait_cnt <= 8'd0;
            else if (state == S_BUSY && !bus_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == S_BUSY && tmo)
                bus_err <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign finish = bus_ready | tmo;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            S_IDLE: begin
                stall = req;
                if (req)
                    state_nx = illegal ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                if (finish)
                    state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0000;
            bus_wdata  <= 32'h0;
            load_data  <= 32'h0;
            access_err <= 1'b0;
            op_f3      <= 3'b000;
            op_ofs     <= 2'b00;
        end else begin
            access_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            access_err <= 1'b1;
                            load_data  <= 32'h0;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= be_nx;
                            bus_wdata <= wdata_nx;
                            op_f3     <= funct3;
                            op_ofs    <= addr[1:0];
                        end
                    end
                end
                S_BUSY: begin
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            load_data <= ext;
                    end else if (tmo) begin
                        bus_req   <= 1'b0;
                        load_data <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: bus handshake, lane/extension results, errors, reset abort.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] load_data;
    logic        access_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .load_data(load_data), .access_err(access_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge with the DUT idle; returns one cycle after DONE.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int waits,
                             input logic [31:0] rdata, input int e_stall,
                             input int e_req, input logic [31:0] e_ld,
                             input logic e_aerr, input logic e_berr,
                             input logic [3:0] e_be, input logic [31:0] e_wd,
                             input logic e_we);
        int          stall_n = 0;
        int          req_n = 0;
        int          busy = 0;
        logic        done = 1'b0;
        logic        stable = 1'b1;
        logic [31:0] ld = 32'h0;
        logic        aerr = 1'b0;
        logic        berr = 1'b0;
        logic        post = 1'b0;
        logic [3:0]  c_be = 4'h0;
        logic [31:0] c_wd = 32'h0;
        logic [31:0] c_ba = 32'h0;
        logic        c_we = 1'b0;

        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (bus_req === 1'b1) begin
                if (busy == 0) begin
                    c_be = bus_be; c_wd = bus_wdata; c_ba = bus_addr; c_we = bus_we;
                end else if (bus_be !== c_be || bus_wdata !== c_wd ||
                             bus_addr !== c_ba || bus_we !== c_we) begin
                    stable = 1'b0;
                end
                bus_ready = (busy == waits);
                bus_rdata = bus_ready ? rdata : 32'hDEADBEEF;
                busy++;
                req_n++;
            end else begin
                bus_ready = 1'b0;
                bus_rdata = 32'hDEADBEEF;
            end
            #1;
            if (stall === 1'b1) begin
                stall_n++;
                tick();
            end else if (cyc > 0) begin
                done = 1'b1;
                ld   = load_data;
                aerr = access_err;
                berr = bus_err;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                tick();
                post = access_err | bus_err | stall | bus_req;
                break;
            end else begin
                tick();
            end
        end
        bus_ready = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;

        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(e_stall));
        chk({tag, "_req_cycles"}, 32'(req_n), 32'(e_req));
        chk({tag, "_load_data"}, ld, e_ld);
        chk({tag, "_access_err"}, 32'(aerr), 32'(e_aerr));
        chk({tag, "_bus_err"}, 32'(berr), 32'(e_berr));
        chk({tag, "_after_done"}, 32'(post), 32'd0);
        if (e_req > 0) begin
            chk({tag, "_bus_be"}, 32'(c_be), 32'(e_be));
            chk({tag, "_bus_wdata"}, c_wd, e_wd);
            chk({tag, "_bus_we"}, 32'(c_we), 32'(e_we));
            chk({tag, "_bus_addr"}, c_ba, {a[31:2], 2'b00});
            chk({tag, "_stable"}, 32'(stable), 32'd1);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_access_err", 32'(access_err), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        tick();

        //         tag      rd    wr    f3      addr          wdata         wt rdata         st rq load         ae    be    be      bus_wdata     we
        do_access("lw100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h12345678, 2, 1, 32'h12345678, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);
        do_access("lb203", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF0011, 2, 1, 32'hFFFFFF80, 1'b0, 1'b0, 4'h8, 32'h0, 1'b0);
        do_access("lbu203", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF0011, 2, 1, 32'h00000080, 1'b0, 1'b0, 4'h8, 32'h0, 1'b0);
        do_access("sh42", 1'b0, 1'b1, 3'b001, 32'h42, 32'hAAAA1234, 3, 32'h0, 5, 4, 32'h00000080, 1'b0, 1'b0, 4'hC, 32'h12341234, 1'b1);
        do_access("lw101", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        do_access("lh102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'hBEEF0000, 3, 2, 32'hFFFFBEEF, 1'b0, 1'b0, 4'hC, 32'h0, 1'b0);
        do_access("rdwr", 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        do_access("lhu102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'hBEEF0000, 2, 1, 32'h0000BEEF, 1'b0, 1'b0, 4'hC, 32'h0, 1'b0);
        do_access("sb001", 1'b0, 1'b1, 3'b000, 32'h1, 32'h12345655, 0, 32'h0, 2, 1, 32'h0000BEEF, 1'b0, 1'b0, 4'h2, 32'h55555555, 1'b1);
        do_access("sw008", 1'b0, 1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 2, 32'h0, 4, 3, 32'h0000BEEF, 1'b0, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1);
        do_access("sbad", 1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        do_access("lbad", 1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        do_access("lh001", 1'b1, 1'b0, 3'b001, 32'h1, 32'h0, 0, 32'h0, 1, 0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        do_access("lb001", 1'b1, 1'b0, 3'b000, 32'h1, 32'h0, 0, 32'h0000C300, 2, 1, 32'hFFFFFFC3, 1'b0, 1'b0, 4'h2, 32'h0, 1'b0);

        // Reset in the second BUSY cycle aborts the access without a DONE cycle.
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h300;
        bus_ready = 1'b0;
        tick();
        chk("rstmid_busy1_req", 32'(bus_req), 32'd1);
        tick();
        chk("rstmid_busy2_req", 32'(bus_req), 32'd1);
        rst      = 1'b1;
        mem_read = 1'b0;
        tick();
        chk("rstmid_req_dropped", 32'(bus_req), 32'd0);
        chk("rstmid_no_err", 32'(access_err), 32'd0);
        chk("rstmid_load_data", load_data, 32'h0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_idle_req", 32'(bus_req), 32'd0);
        do_access("lw300", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0A0B0C0D, 2, 1, 32'h0A0B0C0D, 1'b0, 1'b0, 4'hF, 32'h0, 1'b0);

`ifdef LSU_TIMEOUT_EN
        do_access("lwtmo", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1000, 32'h0, 17, 16, 32'h0, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the single-cycle RV32I core.
- Consumes the MemRead/MemWrite decode from the control unit, plus funct3, the ALU address and the rs2 store data.
- Runs a valid/ready transaction on the data-memory bus and stalls the core until the access completes.
- Returns byte/half/word load data, sign- or zero-extended, for the MemtoReg writeback mux.

Parameters:
- ADDR_W, 32, address width; bus_addr is word-aligned.
- TIMEOUT_CYCLES, 16, bus-wait limit; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request from the control unit.
- mem_write  in  1  store request from the control unit.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  byte address from the ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  hold PC and the register file while high.
- load_data  out  32  extended load result; valid in the DONE cycle.
- access_err  out  1  one-cycle pulse for a misaligned or illegal access.
- bus_req  out  1  bus request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  bus completes the transfer this cycle.
- bus_rdata  in  32  read word; valid when bus_ready is high.
- bus_err  out  1  timeout pulse (feature only).

Behaviour:
- Reset (synchronous, active-high; clk/rst) forces state IDLE.
  - Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data=0, access_err=0, bus_err=0.
  - Reset takes effect at the next clock edge even mid-transaction; bus_req drops at that edge and no DONE is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = mem_read|mem_write, combinational, in the same cycle.
  - Legal access: register bus_addr, bus_we=mem_write, bus_be, bus_wdata; bus_req=1 from the next cycle; go to BUSY.
  - Illegal access: issue no bus request; go to DONE with access_err=1 and load_data=0. Illegal means any of:
    - mem_read and mem_write both high;
    - load funct3 of 011, 110 or 111;
    - store funct3 not in {000, 001, 010};
    - half access with addr[0]=1;
    - word access with addr[1:0]!=0.
- BUSY:
  - stall=1; bus_req=1.
  - bus_addr, bus_we, bus_be and bus_wdata stay stable until bus_ready.
  - On bus_ready: bus_req=0 at the next edge, load_data captured (loads only), go to DONE.
- DONE:
  - stall=0 for exactly one cycle; the core retires the instruction.
  - mem_read/mem_write are ignored in this cycle (same instruction).
  - Go to IDLE next.
  - access_err and bus_err are high only in this cycle.
- Latency:
  - Request seen in cycle N; bus_req high from N+1.
  - bus_ready in cycle N+1+k gives DONE in N+2+k.
  - Minimum 3 cycles per access (k=0).
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- Store data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load extraction:
  - sh = bus_rdata >> (8*addr[1:0]).
  - B: sign-extend sh[7:0]. BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0]. HU: zero-extend sh[15:0].
  - W: bus_rdata.
- Stores leave load_data unchanged. bus_rdata is ignored when bus_ready=0 or bus_we=1.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - An 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle with bus_ready=0.
  - On reaching TIMEOUT_CYCLES: bus_req drops at the next edge, go to DONE with bus_err=1 and load_data=0.
  - A bus_ready in the same cycle as the limit wins: normal completion, no error.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - bus_err is tied to 0.

Test Plan:
- LW at addr 0x100, bus_ready held 1, bus_rdata=0x12345678 -> bus_req high 1 cycle, bus_be=1111, bus_addr=0x100, load_data=0x12345678 in the DONE cycle, stall high exactly 2 cycles.
- LB at addr 0x203, bus_rdata=0x80FF0011 -> bus_be=1000, load_data=0xFFFFFF80; repeated as LBU -> 0x00000080.
- SH at addr 0x42, wdata=0xAAAA1234, bus_ready after 3 wait cycles -> bus_be=1100, bus_wdata=0x12341234, bus_we=1, request fields stable through the waits, stall high 5 cycles.
- LW at addr 0x101 -> no bus_req, access_err pulses 1 cycle, load_data=0, stall high 1 cycle; mem_read=mem_write=1 -> same response.
- rst asserted in the 2nd BUSY cycle -> bus_req=0 and state IDLE after that edge, no DONE cycle, next LW completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, bus_ready held 0 -> bus_req drops after 16 BUSY cycles, bus_err=1 for 1 cycle, load_data=0.
